if_id_fetch_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline buffer.
- Sits between instruction memory/PC+4 adder and the decode stage (UC/BR/sign-extend).
- Holds up to DEPTH fetched (instruction, PC+4) pairs with valid/ready handshakes on both sides.
- Flush discards all entries on taken branch/jump; an empty queue presents a NOP (0x00000000) to decode.

---
 rtl/if_id_fetch_queue_if.sv | 25 ++
 rtl/if_id_fetch_queue.sv | 94 +++++++++
 tb/tb_if_id_fetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_queue_if.sv
// Handshake bundle between fetch (in_*), the IF/ID queue and decode (out_*).
// slave: the queue's view; master: the surrounding fetch/decode logic.
interface if_id_fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc4;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc4;
  logic             flush;

  modport slave (
    input  in_valid, in_instr, in_pc4, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc4
  );

  modport master (
    output in_valid, in_instr, in_pc4, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc4
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: DEPTH-entry FIFO of (instruction, PC+4) pairs, flushable, NOP when empty.
// Optional macro IF_ID_FETCH_QUEUE_BYPASS_EN: empty-queue combinational pass-through to decode.
module if_id_fetch_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  if_id_fetch_queue_if.slave    bus,
  output logic [CW-1:0]         count
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] instr_d [DEPTH];
  logic [WIDTH-1:0] pc4_q   [DEPTH];
  logic [WIDTH-1:0] pc4_d   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             empty, full, bypass, push, pop;
  logic [WIDTH-1:0] head_instr, head_pc4;

  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == FULL);
    bus.in_ready  = ~full & ~bus.flush;
`ifdef IF_ID_FETCH_QUEUE_BYPASS_EN
    // An empty queue shows the incoming pair; it is only stored if decode stalls.
    bypass        = empty & bus.in_valid & bus.out_ready & ~bus.flush;
    bus.out_valid = (~empty | bus.in_valid) & ~bus.flush;
    head_instr    = empty ? bus.in_instr : instr_q[rd_ptr_q];
    head_pc4      = empty ? bus.in_pc4   : pc4_q[rd_ptr_q];
`else
    bypass        = 1'b0;
    bus.out_valid = ~empty & ~bus.flush;
    head_instr    = instr_q[rd_ptr_q];
    head_pc4      = pc4_q[rd_ptr_q];
`endif
    push          = bus.in_valid & bus.in_ready & ~bypass;
    pop           = bus.out_valid & bus.out_ready & ~empty;
    bus.out_instr = bus.out_valid ? head_instr : '0;
    bus.out_pc4   = bus.out_valid ? head_pc4   : '0;
    count         = count_q;
  end

  always_comb begin
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = bus.in_instr;
        pc4_d[wr_ptr_q]   = bus.in_pc4;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue: reset, fill/drain, wrap, full push+pop, flush, bypass.
module tb_if_id_fetch_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] count;
  int            n_checks = 0;
  int            n_errors = 0;

  if_id_fetch_queue_if #(.WIDTH(WIDTH)) bus ();

  if_id_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                       input logic orr, input logic fl);
    bus.in_valid  = iv;
    bus.in_instr  = ii;
    bus.in_pc4    = ip;
    bus.out_ready = orr;
    bus.flush     = fl;
    #1;
  endtask

  logic [31:0] fill_i [4];
  logic [31:0] fill_p [4];
  logic [31:0] qi [$];
  logic [31:0] qp [$];
  int          pushed, popped;
  logic        iv, orr, exp_ir, exp_ov, do_push, do_pop;
  logic [31:0] exp_hi, exp_hp, cur_i, cur_p;

  initial begin
    fill_i[0] = 32'h20080005; fill_p[0] = 32'h4;
    fill_i[1] = 32'h20090003; fill_p[1] = 32'h8;
    fill_i[2] = 32'h01095020; fill_p[2] = 32'hC;
    fill_i[3] = 32'hAC0A0000; fill_p[3] = 32'h10;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc4 = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset raised mid-cycle: outputs must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_pc4", bus.out_pc4, 32'd0);
    #4 rst = 1'b0;
    next();

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_i[i], fill_p[i], 1'b0, 1'b0);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
      next();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_instr", bus.out_instr, fill_i[i]);
      chk("drain_pc4", bus.out_pc4, fill_p[i]);
      next();
      chk("drain_count", 32'(count), 32'(3 - i));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("empty_out_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_out_instr", bus.out_instr, 32'd0);
    chk("empty_out_pc4", bus.out_pc4, 32'd0);

    // Wrap-around: 10 pushes, pops whenever two or more are held
    pushed = 0; popped = 0;
    for (int c = 0; c < 40 && popped < 10; c++) begin
      iv    = (pushed < 10);
      orr   = (qi.size() >= 2) || (pushed == 10);
      cur_i = 32'h10000000 + 32'(pushed);
      cur_p = 32'h40 + 32'(4 * pushed);
      drive(iv, cur_i, cur_p, orr, 1'b0);
      exp_ir = (qi.size() != 4);
      exp_hi = 32'd0; exp_hp = 32'd0;
      if (qi.size() != 0) begin
        exp_ov = 1'b1; exp_hi = qi[0]; exp_hp = qp[0];
      end else begin
`ifdef IF_ID_FETCH_QUEUE_BYPASS_EN
        exp_ov = iv;
        if (iv) begin exp_hi = cur_i; exp_hp = cur_p; end
`else
        exp_ov = 1'b0;
`endif
      end
      chk("wrap_count", 32'(count), 32'(qi.size()));
      chk("wrap_in_ready", 32'(bus.in_ready), 32'(exp_ir));
      chk("wrap_out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("wrap_instr", bus.out_instr, exp_hi);
      chk("wrap_pc4", bus.out_pc4, exp_hp);
      do_push = iv && exp_ir;
      do_pop  = exp_ov && orr;
      if (qi.size() == 0 && do_push && do_pop) begin
        pushed++; popped++;
      end else begin
        if (do_pop) begin void'(qi.pop_front()); void'(qp.pop_front()); popped++; end
        if (do_push) begin qi.push_back(cur_i); qp.push_back(cur_p); pushed++; end
      end
      next();
    end
    chk("wrap_all_popped", 32'(popped), 32'd10);
    chk("wrap_end_count", 32'(count), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_i[i], fill_p[i], 1'b0, 1'b0);
      next();
    end
    drive(1'b1, 32'hDEADBEEF, 32'h99, 1'b1, 1'b0);
    chk("fpp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fpp_out_valid", 32'(bus.out_valid), 32'd1);
    next();
    drive(1'b1, 32'h8C0B0004, 32'h14, 1'b0, 1'b0);
    chk("fpp_count3", 32'(count), 32'd3);
    chk("fpp_head", bus.out_instr, fill_i[1]);
    chk("fpp_in_ready2", 32'(bus.in_ready), 32'd1);
    next();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("fpp_count4", 32'(count), 32'd4);
    next();
    chk("pre_flush_count", 32'(count), 32'd3);

    // Flush with push and pop requested
    drive(1'b1, 32'h12345678, 32'h77, 1'b1, 1'b1);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_instr", bus.out_instr, 32'd0);
    next();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("post_flush_count", 32'(count), 32'd0);
    chk("post_flush_instr", bus.out_instr, 32'd0);
    chk("post_flush_valid", 32'(bus.out_valid), 32'd0);

    // Bypass / one-cycle latency on empty queue
    drive(1'b1, 32'h08000010, 32'h20, 1'b1, 1'b0);
`ifdef IF_ID_FETCH_QUEUE_BYPASS_EN
    chk("byp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("byp_out_instr", bus.out_instr, 32'h08000010);
    next();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_after_valid", 32'(bus.out_valid), 32'd0);
`else
    chk("lat_out_valid0", 32'(bus.out_valid), 32'd0);
    chk("lat_out_instr0", bus.out_instr, 32'd0);
    next();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_out_valid1", 32'(bus.out_valid), 32'd1);
    chk("lat_out_instr1", bus.out_instr, 32'h08000010);
    chk("lat_out_pc4", bus.out_pc4, 32'h20);
    next();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("lat_drained", 32'(count), 32'd0);
`endif

    // Reset mid-operation, between clock edges
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, fill_i[i], fill_p[i], 1'b0, 1'b0);
      next();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_instr", bus.out_instr, 32'd0);
    #1 rst = 1'b0;
    next();
    drive(1'b1, fill_i[3], fill_p[3], 1'b0, 1'b0);
    next();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_head", bus.out_instr, fill_i[3]);
    chk("post_rst_pc4", bus.out_pc4, fill_p[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
